// File: rtl/da_sched.sv
// Dual-channel DAC source scheduler: muted mode switching, starvation watchdog, test ramp.
// Latency: one cycle from source valid to DAC output; mode requests are refused (rdy=0) while a mute runs.
module da_sched #(
    parameter int DW        = 14,
    parameter int MUTE_CYC  = 16,
    parameter int TIMEOUT   = 1024,
    parameter int RAMP_STEP = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    mode_req,
    input  logic          mode_req_vld,
    output logic          mode_req_rdy,
    input  logic          ask_vld,
    input  logic [DW-1:0] ask_data,
    input  logic          qpsk_vld,
    input  logic [DW-1:0] qpsk_i,
    input  logic [DW-1:0] qpsk_q,
    output logic [DW-1:0] real_da1,
    output logic [DW-1:0] real_da2,
    output logic [1:0]    cur_mode,
    output logic          busy,
    output logic          underrun
);

    localparam logic [DW-1:0] MID = {1'b1, {(DW-1){1'b0}}};
    localparam int MW = $clog2(MUTE_CYC + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] M_OFF  = 2'd0;
    localparam logic [1:0] M_ASK  = 2'd1;
    localparam logic [1:0] M_QPSK = 2'd2;
    localparam logic [1:0] M_TEST = 2'd3;

    typedef enum logic [1:0] {S_OFF, S_RUN, S_MUTE} state_t;

    state_t        r_state;
    logic [1:0]    r_cur_mode;
    logic [1:0]    r_target;
    logic [MW-1:0] r_mute_cnt;
    logic [WW-1:0] r_wd_cnt;
    logic [DW-1:0] r_ramp;
    logic [DW-1:0] r_da1;
    logic [DW-1:0] r_da2;
    logic          r_underrun;

    state_t        w_state_nxt;
    logic [1:0]    w_cur_mode_nxt;
    logic [1:0]    w_target_nxt;
    logic [MW-1:0] w_mute_cnt_nxt;
    logic [WW-1:0] w_wd_cnt_nxt;
    logic [DW-1:0] w_ramp_nxt;
    logic [DW-1:0] w_da1_nxt;
    logic [DW-1:0] w_da2_nxt;
    logic          w_underrun_nxt;
    logic          w_req_acc;
    logic          w_src_vld;

    assign mode_req_rdy = (r_state != S_MUTE);
    assign busy         = (r_state == S_MUTE);
    assign real_da1     = r_da1;
    assign real_da2     = r_da2;
    assign cur_mode     = r_cur_mode;
    assign underrun     = r_underrun;

    assign w_req_acc = mode_req_vld & mode_req_rdy;
    assign w_src_vld = ((r_cur_mode == M_ASK) & ask_vld) | ((r_cur_mode == M_QPSK) & qpsk_vld);

    always_comb begin
        w_state_nxt    = r_state;
        w_cur_mode_nxt = r_cur_mode;
        w_target_nxt   = r_target;
        w_mute_cnt_nxt = r_mute_cnt;
        w_wd_cnt_nxt   = r_wd_cnt;
        w_ramp_nxt     = r_ramp;
        w_da1_nxt      = r_da1;
        w_da2_nxt      = r_da2;
        w_underrun_nxt = 1'b0;

        case (r_state)
            S_OFF: begin
                w_da1_nxt = MID;
                w_da2_nxt = MID;
                if (w_req_acc && mode_req != M_OFF) begin
                    w_target_nxt   = mode_req;
                    w_mute_cnt_nxt = '0;
                    w_state_nxt    = S_MUTE;
                end
            end
            S_MUTE: begin
                w_da1_nxt = MID;
                w_da2_nxt = MID;
                if (r_mute_cnt == MW'(MUTE_CYC - 1)) begin
                    w_cur_mode_nxt = r_target;
                    w_wd_cnt_nxt   = '0;
                    w_state_nxt    = (r_target == M_OFF) ? S_OFF : S_RUN;
                    if (r_target == M_TEST) begin
                        w_ramp_nxt = '0;
                    end
                end else begin
                    w_mute_cnt_nxt = r_mute_cnt + 1'b1;
                end
            end
            S_RUN: begin
                if (w_req_acc && mode_req != r_cur_mode) begin
                    // switch beats any sample arriving in the same cycle
                    w_target_nxt   = mode_req;
                    w_mute_cnt_nxt = '0;
                    w_state_nxt    = S_MUTE;
                    w_da1_nxt      = MID;
                    w_da2_nxt      = MID;
                end else if (r_cur_mode == M_TEST) begin
                    w_ramp_nxt = r_ramp + DW'(RAMP_STEP);
                    w_da1_nxt  = r_ramp;
                    w_da2_nxt  = ~r_ramp;
                end else if (r_cur_mode == M_ASK || r_cur_mode == M_QPSK) begin
                    if (w_src_vld) begin
                        // the cycle after a sample already counts as one cycle without a fresh one
                        w_wd_cnt_nxt = WW'(1);
                        w_da1_nxt    = (r_cur_mode == M_ASK) ? ask_data : qpsk_i;
                        w_da2_nxt    = (r_cur_mode == M_ASK) ? MID : qpsk_q;
                    end else if (r_wd_cnt >= WW'(TIMEOUT - 1)) begin
                        w_wd_cnt_nxt   = WW'(TIMEOUT);
                        w_underrun_nxt = 1'b1;
                        w_da1_nxt      = MID;
                        w_da2_nxt      = MID;
                    end else begin
                        w_wd_cnt_nxt = r_wd_cnt + 1'b1;
                    end
                end else begin
                    w_da1_nxt = MID;
                    w_da2_nxt = MID;
                end
            end
            default: begin
                w_state_nxt = S_OFF;
                w_da1_nxt   = MID;
                w_da2_nxt   = MID;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_OFF;
            r_cur_mode <= M_OFF;
            r_target   <= M_OFF;
            r_mute_cnt <= '0;
            r_wd_cnt   <= '0;
            r_ramp     <= '0;
            r_da1      <= MID;
            r_da2      <= MID;
            r_underrun <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cur_mode <= w_cur_mode_nxt;
            r_target   <= w_target_nxt;
            r_mute_cnt <= w_mute_cnt_nxt;
            r_wd_cnt   <= w_wd_cnt_nxt;
            r_ramp     <= w_ramp_nxt;
            r_da1      <= w_da1_nxt;
            r_da2      <= w_da2_nxt;
            r_underrun <= w_underrun_nxt;
        end
    end

endmodule

// File: tb/tb_da_sched.sv
// Directed bench for da_sched: every cycle's expected outputs are queued with the stimulus and checked after the edge.
module tb_da_sched;

    localparam int DW = 14;
    localparam logic [DW-1:0] MID = 14'd8192;

    logic          clk;
    logic          rst;
    logic [1:0]    mode_req;
    logic          mode_req_vld;
    logic          mode_req_rdy;
    logic          ask_vld;
    logic [DW-1:0] ask_data;
    logic          qpsk_vld;
    logic [DW-1:0] qpsk_i;
    logic [DW-1:0] qpsk_q;
    logic [DW-1:0] real_da1;
    logic [DW-1:0] real_da2;
    logic [1:0]    cur_mode;
    logic          busy;
    logic          underrun;

    da_sched #(.DW(DW), .MUTE_CYC(16), .TIMEOUT(1024), .RAMP_STEP(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .mode_req     (mode_req),
        .mode_req_vld (mode_req_vld),
        .mode_req_rdy (mode_req_rdy),
        .ask_vld      (ask_vld),
        .ask_data     (ask_data),
        .qpsk_vld     (qpsk_vld),
        .qpsk_i       (qpsk_i),
        .qpsk_q       (qpsk_q),
        .real_da1     (real_da1),
        .real_da2     (real_da2),
        .cur_mode     (cur_mode),
        .busy         (busy),
        .underrun     (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // packed as {da1, da2, cur_mode, busy, underrun, rdy}
    typedef struct {
        string       tag;
        logic [32:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // queue the outputs expected after the coming edge, clock, then score them
    task automatic cyc(input string tag, input logic [DW-1:0] e1, input logic [DW-1:0] e2,
                       input logic [1:0] em, input logic eb, input logic eu, input logic er);
        exp_t e;
        exp_t g;
        logic [32:0] obs;
        e.tag = tag;
        e.v   = {e1, e2, em, eb, eu, er};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        g   = exp_q.pop_front();
        obs = {real_da1, real_da2, cur_mode, busy, underrun, mode_req_rdy};
        n_vec++;
        assert (obs === g.v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", g.tag, obs, g.v);
        end
    endtask

    initial begin
        logic [DW-1:0] rv;
        rst = 1'b1; mode_req = 2'd0; mode_req_vld = 1'b0;
        ask_vld = 1'b0; ask_data = '0; qpsk_vld = 1'b0; qpsk_i = '0; qpsk_q = '0;
        cyc("reset", MID, MID, 2'd0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) cyc("idle", MID, MID, 2'd0, 1'b0, 1'b0, 1'b1);

        // mode 0 request while off is a no-op
        mode_req = 2'd0; mode_req_vld = 1'b1;
        cyc("off_req0", MID, MID, 2'd0, 1'b0, 1'b0, 1'b1);

        // QPSK request with samples already streaming
        mode_req = 2'd2; qpsk_vld = 1'b1; qpsk_i = 14'd100; qpsk_q = 14'd16000;
        cyc("q_mute1", MID, MID, 2'd0, 1'b1, 1'b0, 1'b0);
        mode_req_vld = 1'b0;
        for (int c = 2; c <= 16; c++) begin
            if (c == 5) begin
                mode_req = 2'd1; mode_req_vld = 1'b1;
            end else begin
                mode_req_vld = 1'b0;
            end
            cyc("q_mute", MID, MID, 2'd0, 1'b1, 1'b0, 1'b0);
        end
        mode_req_vld = 1'b0;
        cyc("q_mode", MID, MID, 2'd2, 1'b0, 1'b0, 1'b1);
        cyc("q_first", 14'd100, 14'd16000, 2'd2, 1'b0, 1'b0, 1'b1);
        qpsk_i = 14'd3; qpsk_q = 14'd16383;
        cyc("q_samp2", 14'd3, 14'd16383, 2'd2, 1'b0, 1'b0, 1'b1);
        qpsk_vld = 1'b0; qpsk_i = 14'd55; ask_vld = 1'b1; ask_data = 14'd999;
        cyc("q_hold", 14'd3, 14'd16383, 2'd2, 1'b0, 1'b0, 1'b1);
        ask_vld = 1'b0;
        mode_req = 2'd2; mode_req_vld = 1'b1; qpsk_vld = 1'b1; qpsk_i = 14'd7; qpsk_q = 14'd9;
        cyc("q_same_req", 14'd7, 14'd9, 2'd2, 1'b0, 1'b0, 1'b1);

        // switch to ASK collides with a QPSK sample: switch wins
        mode_req = 2'd1; qpsk_i = 14'd1111; ask_vld = 1'b1; ask_data = 14'd12000;
        cyc("a_collide", MID, MID, 2'd2, 1'b1, 1'b0, 1'b0);
        mode_req_vld = 1'b0;
        for (int c = 2; c <= 16; c++) cyc("a_mute", MID, MID, 2'd2, 1'b1, 1'b0, 1'b0);
        cyc("a_mode", MID, MID, 2'd1, 1'b0, 1'b0, 1'b1);
        cyc("a_first", 14'd12000, MID, 2'd1, 1'b0, 1'b0, 1'b1);
        ask_vld = 1'b0; qpsk_vld = 1'b1; qpsk_i = 14'd5;
        for (int i = 0; i < 1022; i++) cyc("a_hold", 14'd12000, MID, 2'd1, 1'b0, 1'b0, 1'b1);
        cyc("a_underrun", MID, MID, 2'd1, 1'b0, 1'b1, 1'b1);
        qpsk_vld = 1'b0;
        cyc("a_under_hold", MID, MID, 2'd1, 1'b0, 1'b1, 1'b1);
        ask_vld = 1'b1; ask_data = 14'd500;
        cyc("a_recover", 14'd500, MID, 2'd1, 1'b0, 1'b0, 1'b1);
        ask_vld = 1'b0;
        for (int i = 0; i < 1022; i++) cyc("a_hold2", 14'd500, MID, 2'd1, 1'b0, 1'b0, 1'b1);
        ask_vld = 1'b1; ask_data = 14'd777;
        cyc("a_vld_at_timeout", 14'd777, MID, 2'd1, 1'b0, 1'b0, 1'b1);
        ask_vld = 1'b0;

        // TEST ramp, including the wrap
        mode_req = 2'd3; mode_req_vld = 1'b1;
        cyc("t_mute1", MID, MID, 2'd1, 1'b1, 1'b0, 1'b0);
        mode_req_vld = 1'b0;
        for (int c = 2; c <= 16; c++) cyc("t_mute", MID, MID, 2'd1, 1'b1, 1'b0, 1'b0);
        cyc("t_mode", MID, MID, 2'd3, 1'b0, 1'b0, 1'b1);
        rv = '0;
        for (int k = 0; k <= 260; k++) begin
            cyc("t_ramp", rv, ~rv, 2'd3, 1'b0, 1'b0, 1'b1);
            rv = rv + 14'd64;
        end

        // reset during the fifth mute cycle discards the pending target
        mode_req = 2'd2; mode_req_vld = 1'b1; qpsk_vld = 1'b1; qpsk_i = 14'd42; qpsk_q = 14'd43;
        cyc("r_mute1", MID, MID, 2'd3, 1'b1, 1'b0, 1'b0);
        mode_req_vld = 1'b0;
        for (int c = 2; c <= 5; c++) cyc("r_mute", MID, MID, 2'd3, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        cyc("r_reset", MID, MID, 2'd0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) cyc("r_off", MID, MID, 2'd0, 1'b0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/da_sched.md
# da_sched

Dual-channel DAC sample scheduler for the 2ASK/QPSK modulator. It sits between the modulation sources (2ASK amplitude stream, QPSK I/Q stream, built-in test ramp) and the two-channel DAC output register, and selects which source drives each DAC channel. On every mode change it runs a mute sequence so no glitched samples reach the DAC. It also detects starvation of the active source and parks the outputs at midscale.

## Interface
Parameters:
- DW, 14, DAC sample width (offset binary)
- MUTE_CYC, 16, midscale cycles inserted on every mode switch (≥1)
- TIMEOUT, 1024, cycles without a valid sample before underrun (≥2)
- RAMP_STEP, 64, test-ramp increment per cycle

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- mode_req  in  2  requested mode: 0 OFF, 1 ASK, 2 QPSK, 3 TEST
- mode_req_vld  in  1  request strobe
- mode_req_rdy  out  1  scheduler can accept a request
- ask_vld  in  1  2ASK sample valid
- ask_data  in  DW  2ASK sample
- qpsk_vld  in  1  QPSK I/Q pair valid
- qpsk_i  in  DW  QPSK in-phase sample
- qpsk_q  in  DW  QPSK quadrature sample
- real_da1  out  DW  DAC channel 1 sample
- real_da2  out  DW  DAC channel 2 sample
- cur_mode  out  2  mode currently driving the outputs
- busy  out  1  mute sequence in progress
- underrun  out  1  active source starved

## Operation
- MID = 2^(DW-1) (8192 for DW=14).
- States: S_OFF, S_RUN, S_MUTE.
- S_OFF: real_da1 = real_da2 = MID, cur_mode = 0. An accepted request with mode ≠ 0 loads the target and moves to S_MUTE. A request with mode 0 is accepted and has no effect.
- S_RUN: outputs follow cur_mode.
  - ASK: on ask_vld, real_da1 ← ask_data and real_da2 ← MID.
  - QPSK: on qpsk_vld, real_da1 ← qpsk_i and real_da2 ← qpsk_q.
  - TEST: ramp register r += RAMP_STEP each cycle, wrapping mod 2^DW. real_da1 ← r, real_da2 ← ~r.
  - Between valids, outputs hold the last sample. Valids from inactive sources are ignored.
- Request in S_RUN:
  - mode == cur_mode: accepted, no effect.
  - Otherwise: load target, clear mute counter, go to S_MUTE.
- S_MUTE: outputs forced to MID and busy = 1. After MUTE_CYC cycles, cur_mode ← target; the next state is S_OFF if target = 0, else S_RUN. On entering TEST, r is cleared to 0.
- mode_req_rdy = 1 in S_OFF and S_RUN, 0 in S_MUTE. A request is accepted when mode_req_vld & mode_req_rdy; requests while not ready are ignored.
- Underrun (ASK and QPSK only):
  - A watchdog counts cycles since the last active-source valid, saturating at TIMEOUT.
  - When it reaches TIMEOUT: underrun = 1 and outputs go to MID.
  - The next valid clears underrun and the counter, and that sample is output normally.
  - The watchdog is cleared on entry to S_RUN and is inactive in OFF, TEST and MUTE; underrun = 0 in those states.

## Timing
- All outputs are registered. Reset values: real_da1 = real_da2 = MID, cur_mode = 0, busy = 0, underrun = 0, mode_req_rdy = 1, state = S_OFF, counters = 0, r = 0.
- Sample latency: a valid in cycle n appears on real_da* in cycle n+1.
- Mode switch:
  - Request accepted in cycle n: busy = 1 and outputs = MID from cycle n+1 through n+MUTE_CYC.
  - Cycle n+MUTE_CYC+1: new cur_mode, busy = 0, rdy = 1.
  - The first new-source sample can appear in cycle n+MUTE_CYC+2.
- Simultaneous request and valid in S_RUN: the switch wins, the sample is dropped, and outputs = MID next cycle.
- Simultaneous valid and watchdog reaching TIMEOUT: the valid wins; no underrun.
- rst asserted mid-operation (including during S_MUTE): everything returns to reset values on the next clock edge and the pending target is discarded.

## Test plan
- Reset, then idle 10 cycles → real_da1 = real_da2 = 8192, cur_mode = 0, rdy = 1, busy = 0.
- Request QPSK at cycle 0, then drive qpsk_vld with I = 100, Q = 16000 every cycle → busy high for cycles 1–16, cur_mode = 2 at cycle 17, and outputs 100/16000 from cycle 18.
- In ASK, drive ask_data = 12000, then stop valids → outputs hold 12000 for 1023 cycles, then underrun = 1 with outputs 8192; the next ask_vld with 500 → underrun = 0 and real_da1 = 500 one cycle later.
- In TEST with RAMP_STEP = 64 → real_da1 increments by 64 per cycle, wraps 16320 → 0, and real_da2 = ~real_da1 every cycle.
- Request ASK while in QPSK mute (rdy = 0) → the request is ignored and cur_mode = 2 after the mute completes. A request to the same mode in S_RUN → no busy pulse.
- Assert rst at mute cycle 5 → the next cycle shows reset values, and the mode stays OFF after rst is released.
